// File: rtl/l2_bus_pkg.sv
// Shared definitions for the L2 shared-bus controller: operation codes,
// snoop response codes and the transaction FSM state encoding.
// No ports (package).
package l2_bus_pkg;

  localparam logic [7:0] OP_READ       = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] OP_RWIM       = 8'h03;
  localparam logic [7:0] OP_INVALIDATE = 8'h04;

  localparam logic [1:0] SNP_NOHIT = 2'b00;
  localparam logic [1:0] SNP_HIT   = 2'b01;
  localparam logic [1:0] SNP_HITM  = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SNOOP = 3'd2,
    DATA  = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/shared_bus_controller_if.sv
// Bundle of requester, shared-bus, snoop and memory handshake signals.
//   slave  : the controller's view (requests/snoop/ready in, bus/grant out)
//   master : the environment's view (requesters, snoop agents, memory)
// Signals: req_i, op_i, addr_i (per-requester, packed slices), gnt_o,
//   bus_valid_o, bus_op_o, bus_addr_o, snoop_i, mem_ready_i, done_o,
//   snoop_res_o, error_o, busy_o.
interface shared_bus_controller_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int OP_W    = 8
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ*OP_W-1:0]   op_i;
  logic [NUM_REQ*ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic                      bus_valid_o;
  logic [OP_W-1:0]           bus_op_o;
  logic [ADDR_W-1:0]         bus_addr_o;
  logic [1:0]                snoop_i;
  logic                      mem_ready_i;
  logic                      done_o;
  logic [1:0]                snoop_res_o;
  logic                      error_o;
  logic                      busy_o;

  modport slave (
    input  req_i, op_i, addr_i, snoop_i, mem_ready_i,
    output gnt_o, bus_valid_o, bus_op_o, bus_addr_o, done_o, snoop_res_o,
           error_o, busy_o
  );

  modport master (
    output req_i, op_i, addr_i, snoop_i, mem_ready_i,
    input  gnt_o, bus_valid_o, bus_op_o, bus_addr_o, done_o, snoop_res_o,
           error_o, busy_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick of the first set request
// at or after the pointer (wrapping), plus the pointer register, which
// advances to winner+1 when en_i accepts a pick.
// Ports: clk, reset (async, active-high), req_i, en_i, gnt_o (one-hot),
//   winner_o (index of gnt_o), any_o (some request present).
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   winner_o,
  output logic               any_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    any_o    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // ptr + k modulo NUM_REQ; both terms are < NUM_REQ so one subtract suffices
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        winner_o   = idx;
        gnt_o[idx] = 1'b1;
      end
    end
    ptr_d = (winner_o == PTR_W'(NUM_REQ-1)) ? '0 : winner_o + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              ptr_q <= '0;
    else if (en_i && any_o) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/shared_bus_controller.sv
// Shares the snooped L2 bus among NUM_REQ requesters. A round-robin pick in
// IDLE captures the winner's op/address, then the FSM runs ADDR (address
// phase on the bus), SNOOP (SNOOP_CYCLES cycles merging snoop_i by
// HITM > HIT > NOHIT), DATA (only for READ/WRITE/RWIM, waits for
// mem_ready_i or times out) and DONE (one-cycle completion pulse).
// Ports: clk, reset (async, active-high), bus (shared_bus_controller_if.slave).
module shared_bus_controller
  import l2_bus_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int ADDR_W       = 32,
  parameter  int OP_W         = 8,
  parameter  int SNOOP_CYCLES = 2,
  parameter  int TIMEOUT      = 64,
  localparam int PTR_W        = $clog2(NUM_REQ)
) (
  input logic                     clk,
  input logic                     reset,
  shared_bus_controller_if.slave  bus
);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          snp_q, snp_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [PTR_W-1:0]    arb_win;
  logic                arb_any;
  logic                arb_en;

  function automatic logic [1:0] snoop_merge(input logic [1:0] acc,
                                             input logic [1:0] smp);
    // reserved 2'b11 counts as HITM, so any set MSB means HITM
    if (acc == SNP_HITM || smp[1])        return SNP_HITM;
    if (acc == SNP_HIT  || smp == SNP_HIT) return SNP_HIT;
    return SNP_NOHIT;
  endfunction

  function automatic logic has_data(input logic [OP_W-1:0] op);
    return (op == OP_W'(OP_READ)) || (op == OP_W'(OP_WRITE)) ||
           (op == OP_W'(OP_RWIM));
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req_i    (bus.req_i),
    .en_i     (arb_en),
    .gnt_o    (arb_gnt),
    .winner_o (arb_win),
    .any_o    (arb_any)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    snp_d   = snp_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          arb_en  = 1'b1;
          gnt_d   = arb_gnt;
          op_d    = bus.op_i[arb_win*OP_W +: OP_W];
          addr_d  = bus.addr_i[arb_win*ADDR_W +: ADDR_W];
          snp_d   = SNP_NOHIT;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        cnt_d   = '0;
        state_d = SNOOP;
      end
      SNOOP: begin
        snp_d = snoop_merge(snp_q, bus.snoop_i);
        if (cnt_q == 8'(SNOOP_CYCLES-1)) begin
          cnt_d   = '0;
          state_d = has_data(op_q) ? DATA : DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        // ready has priority over a timeout expiring in the same cycle
        if (bus.mem_ready_i) begin
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT-1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      snp_q   <= SNP_NOHIT;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      snp_q   <= snp_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.bus_valid_o = (state_q == ADDR);
  assign bus.bus_op_o    = (state_q != IDLE) ? op_q : '0;
  assign bus.bus_addr_o  = (state_q != IDLE) ? addr_q : '0;
  assign bus.done_o      = (state_q == DONE);
  assign bus.snoop_res_o = (state_q == DONE) ? snp_q : SNP_NOHIT;
  assign bus.error_o     = (state_q == DONE) && err_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule
